// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive port: receiver states,
// status register bit positions and the default MCU port IDs.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int STAT_BUSY       = 0;
  localparam int STAT_NONEMPTY   = 1;
  localparam int STAT_FULL       = 2;
  localparam int STAT_OVERRUN    = 3;
  localparam int STAT_FRAME_ERR  = 4;
  localparam int STAT_PARITY_ERR = 5;

  localparam logic [7:0] DEFAULT_DATA_ID = 8'h30;
  localparam logic [7:0] DEFAULT_STAT_ID = 8'h31;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// Count is one bit wider than the pointers so full and empty differ.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a real pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_port.sv
// UART receiver peripheral on the MCU I/O bus: 8N1 by default, 8E1 when
// UART_RX_PARITY_EN is defined. Bytes land in a FIFO, popped via STAT_ID.
module uart_rx_port
  import uart_rx_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] DATA_ID      = DEFAULT_DATA_ID,
  parameter logic [7:0] STAT_ID      = DEFAULT_STAT_ID,
  parameter int         INT_CYCLES   = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       RX,
  input  logic [7:0] PORT_ID,
  input  logic       IO_STRB,
  input  logic [7:0] OUT_PORT,
  output logic [7:0] IN_DATA,
  output logic       INTERRUPT
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int ICNT_W = $clog2(INT_CYCLES + 1);
  localparam int CPTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [ICNT_W-1:0] INT_LOAD = ICNT_W'(INT_CYCLES);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t AFTER_DATA = PARITY;
`else
  localparam rx_state_t AFTER_DATA = STOP;
`endif

  rx_state_t          state, state_n;
  logic               rx_meta, rx_sync;
  logic [CNT_W-1:0]   baud_cnt, cnt_n;
  logic [2:0]         bit_cnt, bit_n;
  logic [7:0]         shift, shift_n;
  logic               enq, frame_set, ovr_set, accept;
  logic               strb_q, pop_req;
  logic               overrun, frame_err;
  logic [ICNT_W-1:0]  int_cnt;
  logic [7:0]         fifo_head, status;
  logic               fifo_full, fifo_empty;
  logic [CPTR_W-1:0]  fifo_count;
  logic               unused_out_port;
`ifdef UART_RX_PARITY_EN
  logic               parity_err, par_set;
`endif

  assign unused_out_port = ^OUT_PORT;
  assign pop_req   = IO_STRB && (PORT_ID == STAT_ID) && !strb_q;
  assign accept    = enq && (!fifo_full || pop_req);
  assign ovr_set   = enq && fifo_full && !pop_req;
  assign INTERRUPT = (int_cnt != '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      strb_q    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      int_cnt   <= '0;
    end else begin
      rx_meta   <= RX;
      rx_sync   <= rx_meta;
      state     <= state_n;
      baud_cnt  <= cnt_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      strb_q    <= IO_STRB;
      overrun   <= (overrun && !pop_req) || ovr_set;
      frame_err <= (frame_err && !pop_req) || frame_set;
      if (accept)              int_cnt <= INT_LOAD;
      else if (int_cnt != '0)  int_cnt <= int_cnt - 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) parity_err <= 1'b0;
    else          parity_err <= (parity_err && !pop_req) || par_set;
  end
`endif

  // Counter resets to 0 on each state hand-off; START waits half a bit to
  // land all later samples mid-bit.
  always_comb begin
    state_n   = state;
    cnt_n     = baud_cnt + 1'b1;
    bit_n     = bit_cnt;
    shift_n   = shift;
    enq       = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        bit_n = '0;
        if (!rx_sync) state_n = START;
      end
      START: if (baud_cnt == HALF_CNT) begin
        cnt_n   = '0;
        state_n = rx_sync ? IDLE : DATA;
      end
      DATA: if (baud_cnt == LAST_CNT) begin
        cnt_n   = '0;
        shift_n = {rx_sync, shift[7:1]};
        bit_n   = bit_cnt + 1'b1;
        if (bit_cnt == 3'd7) state_n = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (baud_cnt == LAST_CNT) begin
        cnt_n = '0;
        if (rx_sync != ^shift) begin
          par_set = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = STOP;
        end
      end
`endif
      STOP: if (baud_cnt == LAST_CNT) begin
        cnt_n     = '0;
        state_n   = IDLE;
        enq       = rx_sync;
        frame_set = !rx_sync;
      end
      default: state_n = IDLE;
    endcase
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (accept),
    .pop   (pop_req),
    .din   (shift),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status                 = '0;
    status[STAT_BUSY]      = (state != IDLE);
    status[STAT_NONEMPTY]  = (fifo_count != '0);
    status[STAT_FULL]      = fifo_full;
    status[STAT_OVERRUN]   = overrun;
    status[STAT_FRAME_ERR] = frame_err;
`ifdef UART_RX_PARITY_EN
    status[STAT_PARITY_ERR] = parity_err;
`endif
    IN_DATA = 8'h00;
    if (PORT_ID == DATA_ID)      IN_DATA = fifo_empty ? 8'h00 : fifo_head;
    else if (PORT_ID == STAT_ID) IN_DATA = status;
  end

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed self-checking bench for uart_rx_port at 16 clocks per bit:
// byte reception, interrupt pulse, FIFO pop/overrun, frame error, glitch, reset abort.
module tb_uart_rx_port;

  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       RX = 1'b1;
  logic [7:0] PORT_ID = 8'h00;
  logic       IO_STRB = 1'b0;
  logic [7:0] OUT_PORT = 8'h00;
  logic [7:0] IN_DATA;
  logic       INTERRUPT;

  int errors = 0;
  int checks = 0;
  int cycleCount = 0;
  int intTotal = 0;
  int lastRise = -1;
  logic intPrev = 1'b0;

  typedef struct {
    bit         doPop;
    logic [7:0] portId;
    logic [7:0] expData;
    string      name;
  } vec_t;

  vec_t vecs[10];

  uart_rx_port #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .DATA_ID(8'h30), .STAT_ID(8'h31), .INT_CYCLES(4)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .RX        (RX),
    .PORT_ID   (PORT_ID),
    .IO_STRB   (IO_STRB),
    .OUT_PORT  (OUT_PORT),
    .IN_DATA   (IN_DATA),
    .INTERRUPT (INTERRUPT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycleCount++;

  // Interrupt monitor: total high cycles and the cycle of the latest rising edge.
  always @(negedge CLK) begin
    if (INTERRUPT) intTotal++;
    if (INTERRUPT && !intPrev) lastRise = cycleCount;
    intPrev = INTERRUPT;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] port, input logic [7:0] expected);
    PORT_ID = port;
    @(negedge CLK);
    checks++;
    if (IN_DATA !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, IN_DATA, expected);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic popStrobe(input int n);
    PORT_ID = 8'h31;
    IO_STRB = 1'b1;
    waitCycles(n);
    IO_STRB = 1'b0;
    waitCycles(1);
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stopBit);
    RX = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      waitCycles(CPB);
    end
    RX = stopBit;
    waitCycles(CPB);
    RX = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.doPop) popStrobe(3);
    checkOutput(v.name, v.portId, v.expData);
  endtask

  initial begin
    int snap;
    int startCycle;

    vecs[0] = '{1'b0, 8'h31, 8'h0E, "stat_overrun_full"};
    vecs[1] = '{1'b0, 8'h30, 8'h01, "head_byte1"};
    vecs[2] = '{1'b1, 8'h30, 8'h02, "head_byte2"};
    vecs[3] = '{1'b0, 8'h31, 8'h02, "stat_overrun_cleared"};
    vecs[4] = '{1'b1, 8'h30, 8'h03, "head_byte3"};
    vecs[5] = '{1'b1, 8'h30, 8'h04, "head_byte4"};
    vecs[6] = '{1'b0, 8'h31, 8'h02, "stat_one_left"};
    vecs[7] = '{1'b1, 8'h30, 8'h00, "data_after_drain"};
    vecs[8] = '{1'b0, 8'h31, 8'h00, "stat_after_drain"};
    vecs[9] = '{1'b0, 8'h55, 8'h00, "unmapped_port"};

    waitCycles(3);
    checkOutput("reset_status", 8'h31, 8'h00);
    checkOutput("reset_data", 8'h30, 8'h00);
    checkValue("reset_interrupt", int'(INTERRUPT), 0);
    RESET_N = 1'b1;
    waitCycles(3);

    $display("[TB] single byte A5");
    snap = intTotal;
    startCycle = cycleCount;
    sendFrame(8'hA5, 1'b1);
    waitCycles(10);
    checkValue("int_pulse_len", intTotal - snap, 4);
    checkValue("int_latency", int'(lastRise > startCycle && lastRise - startCycle <= 10*CPB + 3), 1);
    checkOutput("data_A5", 8'h30, 8'hA5);
    checkOutput("status_A5", 8'h31, 8'h02);

    $display("[TB] two-cycle strobe pop");
    popStrobe(2);
    checkOutput("data_after_pop", 8'h30, 8'h00);
    checkOutput("status_after_pop", 8'h31, 8'h00);

    $display("[TB] five bytes into four-deep FIFO");
    for (int b = 1; b <= 5; b++) sendFrame(8'(b), 1'b1);
    waitCycles(10);
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    $display("[TB] frame error");
    snap = intTotal;
    sendFrame(8'h55, 1'b0);
    waitCycles(20);
    checkOutput("frame_err_status", 8'h31, 8'h10);
    checkOutput("frame_err_data", 8'h30, 8'h00);
    checkValue("frame_err_no_int", intTotal - snap, 0);

    $display("[TB] start-bit glitch");
    snap = intTotal;
    RX = 1'b0;
    waitCycles(4);
    RX = 1'b1;
    waitCycles(1);
    checkOutput("glitch_busy", 8'h31, 8'h11);
    waitCycles(20);
    checkOutput("glitch_idle", 8'h31, 8'h10);
    checkValue("glitch_no_int", intTotal - snap, 0);

    $display("[TB] reset during data bit 3");
    RX = 1'b0;
    waitCycles(CPB);
    RX = 1'b0;
    waitCycles(CPB);
    RX = 1'b0;
    waitCycles(CPB);
    RX = 1'b1;
    waitCycles(CPB);
    RX = 1'b1;
    waitCycles(6);
    checkOutput("busy_mid_byte", 8'h31, 8'h11);
    RESET_N = 1'b0;
    checkOutput("status_in_reset", 8'h31, 8'h00);
    waitCycles(2);
    RESET_N = 1'b1;
    waitCycles(20);
    checkOutput("status_after_abort", 8'h31, 8'h00);
    checkOutput("data_after_abort", 8'h30, 8'h00);
    snap = intTotal;
    sendFrame(8'h3C, 1'b1);
    waitCycles(10);
    checkOutput("data_3C", 8'h30, 8'h3C);
    checkOutput("status_3C", 8'h31, 8'h02);
    checkValue("int_pulse_3C", intTotal - snap, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
